// File: rtl/bcd_seg_scanner.sv
// Four-digit multiplexed BCD display driver: snapshots a packed BCD value and
// scans it onto active-low digit enables and seven-segment outputs.
module bcd_seg_scanner #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] q,
    input  logic        load,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        scan_tick
);

    localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

    logic [15:0] snapshot;
    logic [15:0] prescaler;
    logic [1:0]  index;
    logic        tick;
    logic [3:0]  nibble;
    logic        d3_zero;
    logic        d2_zero;
    logic        d1_zero;
    logic        blank;
    logic [6:0]  pattern;
    logic [3:0]  an_next;

    assign tick    = (prescaler == LAST);
    assign nibble  = snapshot[{index, 2'b00} +: 4];
    assign d3_zero = (snapshot[15:12] == 4'd0);
    assign d2_zero = (snapshot[11:8] == 4'd0);
    assign d1_zero = (snapshot[7:4] == 4'd0);
    assign an_next = ~(4'b0001 << index);

    // A digit is blanked only when it and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        if (lzb) begin
            case (index)
                2'd3:    blank = d3_zero;
                2'd2:    blank = d3_zero && d2_zero;
                2'd1:    blank = d3_zero && d2_zero && d1_zero;
                default: blank = 1'b0;
            endcase
        end
    end

    always_comb begin
        pattern = 7'b0111111;
        case (nibble)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        if (blank) begin
            pattern = 7'b1111111;
        end
    end

    // Outputs are registered from the pre-edge index/snapshot/tick, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot  <= 16'd0;
            prescaler <= 16'd0;
            index     <= 2'd0;
            an        <= 4'b1111;
            seg       <= 7'b1111111;
            scan_tick <= 1'b0;
        end else begin
            if (load) begin
                snapshot <= q;
            end
            if (tick) begin
                prescaler <= 16'd0;
                index     <= index + 2'd1;
            end else begin
                prescaler <= prescaler + 16'd1;
            end
            an        <= an_next;
            seg       <= pattern;
            scan_tick <= tick;
        end
    end

endmodule

// File: doc/bcd_seg_scanner.md
BCD_SEG_SCANNER -- requirements
Module: bcd_seg_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, giving clock cycles each digit is driven (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port q, input, 16, packed BCD value {d3,d2,d1,d0}; d0 = q[3:0] is the least significant digit.
REQ-005 SHALL have port load, input, 1, capture strobe for q.
REQ-006 SHALL have port lzb, input, 1, leading-zero-blanking enable.
REQ-007 SHALL have port an, output, 4, active-low digit enables; an[i] drives digit i.
REQ-008 SHALL have port seg, output, 7, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port scan_tick, output, 1, one-cycle pulse on each digit advance.

Function
REQ-010 SHALL hold a 16-bit snapshot register loaded from q on any edge where load=1; otherwise it SHALL hold its value.
REQ-011 SHALL run a prescaler counting 0..SCAN_DIV-1 every cycle; tick = (prescaler == SCAN_DIV-1); prescaler wraps to 0 on tick.
REQ-012 SHALL, for SCAN_DIV=1, assert tick every cycle.
REQ-013 SHALL hold a 2-bit digit index that increments on tick and wraps 3 -> 0.
REQ-014 SHALL register an, seg and scan_tick; each edge they reflect the index, snapshot and tick values present before that edge (one-cycle output latency).
REQ-015 SHALL drive an = one-hot active-low of the index (index 0 -> 4'b1110, 3 -> 4'b0111).
REQ-016 SHALL decode the selected nibble: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
REQ-017 SHALL drive the dash pattern 0111111 for any nibble 10..15.
REQ-018 SHALL, when lzb=1, blank (seg=1111111, an unchanged) digit 3 if d3==0, digit 2 if d3==d2==0, digit 1 if d3==d2==d1==0; digit 0 is never blanked.
REQ-019 SHALL evaluate blanking on the snapshot, and SHALL treat a nonzero invalid nibble as non-zero.
REQ-020 SHALL make load-to-display latency exactly 2 edges: snapshot updates at the load edge, seg reflects it at the following edge if that digit is selected.
REQ-021 SHALL, when load coincides with tick, apply both: new snapshot and new index are used together on the next output edge.
REQ-022 SHALL ignore q when load=0, regardless of q changes.

Reset
REQ-023 SHALL, on an edge with reset=1, clear snapshot, prescaler and index to 0, and set an=4'b1111, seg=7'b1111111, scan_tick=0.
REQ-024 SHALL give reset priority over load and tick on the same edge.
REQ-025 SHALL, on the first edge after reset deasserts, output an=4'b1110, seg=1000000 (digit 0 showing 0).
REQ-026 SHALL restart the scan from digit 0 with prescaler 0 when reset is asserted mid-scan.

Verification
REQ-027 SHALL check reset then free run, SCAN_DIV=4, lzb=0 -> an sequence 1110,1101,1011,0111,1110 each held 4 cycles, seg=1000000 throughout, scan_tick pulsing every 4 cycles.
REQ-028 SHALL check load q=16'h1234 -> while an=1110 seg=0011001 (4); an=1101 0110000; an=1011 0100100; an=0111 1111001.
REQ-029 SHALL check q=16'h0047, lzb=1 -> digits 3,2 seg=1111111, digit 1 0011001, digit 0 1111000; with q=16'h0000 only digit 0 lit showing 1000000.
REQ-030 SHALL check q=16'h0A05, lzb=1 -> digit 3 blank, digit 2 dash 0111111, digit 1 1000000 (not blanked), digit 0 0010010.
REQ-031 SHALL check load on a tick edge and on a non-tick edge while digit 0 is selected -> new digit-0 pattern appears exactly 2 edges after load.
REQ-032 SHALL check reset asserted mid-scan at index 2 with load=1 -> snapshot 0, outputs all-off during reset, an=1110 seg=1000000 on the first edge after release.
